// File: rtl/hs_pkg.sv
// Shared constants for the half-subtractor block: default counter width and
// the saturation ceiling helper used to size the borrow-event counter.
package hs_pkg;

    localparam int unsigned HS_CNT_W_DEFAULT = 8;

    // All-ones value for a w-bit counter; widths of 32 and above clamp to 32 ones.
    function automatic logic [31:0] hs_sat_max(input int unsigned w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam logic [31:0] HS_CNT_MAX_DEFAULT = hs_sat_max(HS_CNT_W_DEFAULT);

endpackage

// File: rtl/half_subtractor_core.sv
// Purely combinational one-bit half subtractor: ip1 - ip2.
module half_subtractor_core (
    input  logic ip1,
    input  logic ip2,
    output logic borrow,
    output logic difference
);

    assign difference = ip1 ^ ip2;
    assign borrow     = ~ip1 & ip2;

endmodule

// File: rtl/hs_bl.sv
// Half subtractor with registered outputs, a post-reset valid flag and a
// saturating count of cycles in which a borrow occurred.
module hs_bl
    import hs_pkg::*;
#(
    parameter int unsigned CNT_W = HS_CNT_W_DEFAULT
) (
    input  logic             ip1,
    input  logic             ip2,
    output logic             borrow,
    output logic             difference,
    input  logic             clk,
    input  logic             rst,
    output logic             borrow_q,
    output logic             difference_q,
    output logic             q_valid,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(hs_sat_max(CNT_W));

    logic             borrow_d;
    logic             difference_d;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    half_subtractor_core u_core (
        .ip1        (ip1),
        .ip2        (ip2),
        .borrow     (borrow),
        .difference (difference)
    );

    always_comb begin
        borrow_d     = borrow;
        difference_d = difference;
        valid_d      = 1'b1;
        cnt_d        = cnt_q;
        // Hold at the ceiling rather than wrapping back to zero.
        if (borrow && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_q     <= 1'b0;
            difference_q <= 1'b0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            borrow_q     <= borrow_d;
            difference_q <= difference_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign q_valid    = valid_q;
    assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_hs_bl.sv
// Self-checking bench for hs_bl: truth-table vectors with the clock stopped,
// then a scoreboard of registered results for directed and random sequences.
module tb_hs_bl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst = 1'b0;
    logic             ip1 = 1'b0;
    logic             ip2 = 1'b0;
    logic             borrow;
    logic             difference;
    logic             borrow_q;
    logic             difference_q;
    logic             q_valid;
    logic [CNT_W-1:0] borrow_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a;
        logic b;
        logic exp_borrow;
        logic exp_diff;
    } vec_t;

    typedef struct {
        logic             bq;
        logic             dq;
        logic             v;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Bench-side reference state for the registered outputs.
    logic             m_valid = 1'b0;
    logic [CNT_W-1:0] m_cnt   = '0;

    always #5 clk = clk_en ? ~clk : 1'b0;

    hs_bl #(.CNT_W(CNT_W)) dut (
        .ip1          (ip1),
        .ip2          (ip2),
        .borrow       (borrow),
        .difference   (difference),
        .clk          (clk),
        .rst          (rst),
        .borrow_q     (borrow_q),
        .difference_q (difference_q),
        .q_valid      (q_valid),
        .borrow_cnt   (borrow_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One clocked transaction: drive on the falling edge, predict, then compare
    // the popped expectation just after the rising edge.
    task automatic step(input logic a, input logic b, input logic r, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        ip1 = a;
        ip2 = b;
        rst = r;
        if (r) begin
            m_valid = 1'b0;
            m_cnt   = '0;
            e.bq    = 1'b0;
            e.dq    = 1'b0;
        end else begin
            m_valid = 1'b1;
            if ((~a & b) && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
            e.bq = ~a & b;
            e.dq = a ^ b;
        end
        e.v   = m_valid;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        $display("txn %s: rst=%0b ip=%0b%0b -> bq=%0b dq=%0b v=%0b cnt=%0d",
                 tag, r, a, b, borrow_q, difference_q, q_valid, borrow_cnt);
        chk({tag, "_borrow_q"},     32'(borrow_q),     32'(got.bq));
        chk({tag, "_difference_q"}, 32'(difference_q), 32'(got.dq));
        chk({tag, "_q_valid"},      32'(q_valid),      32'(got.v));
        chk({tag, "_borrow_cnt"},   32'(borrow_cnt),   32'(got.cnt));
        chk({tag, "_borrow_comb"},  32'(borrow),       32'(~a & b));
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Combinational path with no clock running.
        for (int i = 0; i < 4; i++) begin
            ip1 = vecs[i].a;
            ip2 = vecs[i].b;
            #1;
            $display("txn comb%0d: ip=%0b%0b -> borrow=%0b diff=%0b",
                     i, ip1, ip2, borrow, difference);
            chk($sformatf("comb%0d_borrow", i), 32'(borrow),     32'(vecs[i].exp_borrow));
            chk($sformatf("comb%0d_diff", i),   32'(difference), 32'(vecs[i].exp_diff));
            #1;
        end

        clk_en = 1'b1;

        // Two reset cycles, then a single borrow cycle.
        step(1'b0, 1'b0, 1'b1, "rst0");
        step(1'b1, 1'b1, 1'b1, "rst1");
        step(1'b0, 1'b1, 1'b0, "first01");
        chk("first01_cnt_is_1", 32'(borrow_cnt), 32'd1);
        chk("first01_valid",    32'(q_valid),    32'd1);

        // 10, 11, 01 on consecutive edges.
        step(1'b1, 1'b0, 1'b0, "seq10");
        chk("seq10_dq", 32'(difference_q), 32'd1);
        step(1'b1, 1'b1, 1'b0, "seq11");
        chk("seq11_dq", 32'(difference_q), 32'd0);
        step(1'b0, 1'b1, 1'b0, "seq01");
        chk("seq01_dq",  32'(difference_q), 32'd1);
        chk("seq01_cnt", 32'(borrow_cnt),   32'd2);

        // Reset while counting at 5 with a borrow present.
        step(1'b0, 1'b0, 1'b1, "pre5rst");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "to5");
        chk("at5_cnt", 32'(borrow_cnt), 32'd5);
        step(1'b0, 1'b1, 1'b1, "midrst");
        chk("midrst_cnt",    32'(borrow_cnt), 32'd0);
        chk("midrst_valid",  32'(q_valid),    32'd0);
        chk("midrst_borrow", 32'(borrow),     32'd1);
        step(1'b0, 1'b1, 1'b0, "resume");
        chk("resume_cnt", 32'(borrow_cnt), 32'd1);

        // Saturation: 300 consecutive borrow cycles from zero.
        step(1'b0, 1'b0, 1'b1, "satrst");
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, "sat");
        chk("sat_cnt_255", 32'(borrow_cnt), 32'd255);
        step(1'b0, 1'b1, 1'b0, "sathold");
        chk("sat_hold_255", 32'(borrow_cnt), 32'd255);

        // Random traffic with occasional resets.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
